// File: rtl/issue_ctrl_pkg.sv
// Shared opcode encodings, decoded-field widths and in-flight entry type for the issue controller.
package issue_ctrl_pkg;

  localparam int OP_W   = 2;
  localparam int A_LEN  = 5;
  localparam int INST_W = OP_W + 3 * A_LEN;

  localparam logic [OP_W-1:0] OP_NOP = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB = 2'b10;
  localparam logic [OP_W-1:0] OP_AND = 2'b11;

  typedef struct packed {
    logic             v;
    logic [A_LEN-1:0] addr;
  } entry_t;

endpackage

// File: rtl/issue_ctrl_hazard_cmp.sv
// Compares one source register against every in-flight stage; flags a RAW hazard and a retire-only match.
// ISSUE_FWD_EN: a match only in the retiring stage is forwarded instead of stalling.
module hazard_cmp #(
  parameter int EX_LAT = 2,
  parameter int A_LEN  = 5
) (
  input  logic [A_LEN-1:0]        src,
  input  logic [EX_LAT-1:0]       stage_v,
  input  logic [EX_LAT*A_LEN-1:0] stage_addr,
  output logic                    hazard,
  output logic                    retire_hit
);

  logic src_live;
  logic young_match;
  logic retire_match;

  // r0 is hardwired and can never be the target of a pending write.
  assign src_live = |src;

  always_comb begin
    young_match = 1'b0;
    for (int i = 0; i < EX_LAT - 1; i++) begin
      if (stage_v[i] && (stage_addr[i*A_LEN +: A_LEN] == src)) begin
        young_match = 1'b1;
      end
    end
  end

  assign retire_match = stage_v[EX_LAT-1] &&
                        (stage_addr[(EX_LAT-1)*A_LEN +: A_LEN] == src);

`ifdef ISSUE_FWD_EN
  assign hazard     = src_live && young_match;
  assign retire_hit = src_live && retire_match && !young_match;
`else
  // The retiring write is only visible to register-file reads next cycle.
  assign hazard     = src_live && (young_match || retire_match);
  assign retire_hit = 1'b0;
`endif

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: tracks in-flight writes, stalls fetch on RAW hazards, drives RF writeback.
// ISSUE_FWD_EN: forwards from the retiring stage via fwd_sel1/2 instead of stalling.
module issue_ctrl
  import issue_ctrl_pkg::OP_W, issue_ctrl_pkg::OP_NOP;
#(
  parameter int EX_LAT = 2,
  parameter int A_LEN  = issue_ctrl_pkg::A_LEN
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inst_valid,
  input  logic [OP_W-1:0]  op,
  input  logic [A_LEN-1:0] waddr,
  input  logic [A_LEN-1:0] raddr1,
  input  logic [A_LEN-1:0] raddr2,
  output logic             fetch_stall,
  output logic             issue_valid,
  output logic [OP_W-1:0]  issue_op,
  output logic [A_LEN-1:0] rf_raddr1,
  output logic [A_LEN-1:0] rf_raddr2,
  output logic             wb_en,
  output logic [A_LEN-1:0] wb_addr,
  output logic             fwd_sel1,
  output logic             fwd_sel2,
  output logic [15:0]      stall_cnt
);

  logic [EX_LAT-1:0]       s_v;
  logic [EX_LAT*A_LEN-1:0] s_addr;
  logic [15:0]             stall_cnt_q;

  logic hazard1, hazard2;
  logic retire_hit1, retire_hit2;
  logic load_v;
  logic [A_LEN-1:0] load_addr;

  hazard_cmp #(.EX_LAT(EX_LAT), .A_LEN(A_LEN)) u_cmp1 (
    .src        (raddr1),
    .stage_v    (s_v),
    .stage_addr (s_addr),
    .hazard     (hazard1),
    .retire_hit (retire_hit1)
  );

  hazard_cmp #(.EX_LAT(EX_LAT), .A_LEN(A_LEN)) u_cmp2 (
    .src        (raddr2),
    .stage_v    (s_v),
    .stage_addr (s_addr),
    .hazard     (hazard2),
    .retire_hit (retire_hit2)
  );

  assign issue_valid = inst_valid && !hazard1 && !hazard2;
  assign fetch_stall = inst_valid && (hazard1 || hazard2);
  assign issue_op    = issue_valid ? op : OP_NOP;
  assign rf_raddr1   = raddr1;
  assign rf_raddr2   = raddr2;
  assign fwd_sel1    = issue_valid && retire_hit1;
  assign fwd_sel2    = issue_valid && retire_hit2;

  // Stalls, idle cycles, NOPs and r0 writes all enter as bubbles with a cleared address.
  assign load_v    = issue_valid && (op != OP_NOP) && (|waddr);
  assign load_addr = load_v ? waddr : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s_v    <= '0;
      s_addr <= '0;
    end else begin
      s_v[0]          <= load_v;
      s_addr[0+:A_LEN] <= load_addr;
      for (int i = 1; i < EX_LAT; i++) begin
        s_v[i]                 <= s_v[i-1];
        s_addr[i*A_LEN +: A_LEN] <= s_addr[(i-1)*A_LEN +: A_LEN];
      end
    end
  end

  assign wb_en   = s_v[EX_LAT-1];
  assign wb_addr = s_addr[(EX_LAT-1)*A_LEN +: A_LEN];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_cnt_q <= '0;
    end else if (fetch_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
